ascii_digit_scan_conv: RTL and testbench
========================================

Name: ascii_digit_scan_conv

Overview:
- Parametrised successor to the lab-6 digit scanner. Holds an internal DEPTH x 8 character buffer that the host preloads.
- On go, scans the buffer in order and converts ASCII digit characters in place to their binary values (decimal or hex mode). Stops early after MAX_HITS conversions.
- Then replays every buffer entry on a paced display port for a seven-segment/LED driver.
- Sits between the host/UART loader and the display driver.

Parameters:
- DEPTH, 16, buffer entries (≥2).
- AW, 4, address width; must satisfy 2^AW ≥ DEPTH.
- MAX_HITS, 8, conversions after which the scan stops early (1..DEPTH).
- CW, 5, hit counter width; must hold DEPTH.
- WAIT_CYCLES, 10000, display dwell per entry, in Clk cycles (≥1).

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- go  in  1  start request; level-sampled in IDLE/DONE.
- hex_mode  in  1  0 = decimal digits only; 1 = also A-F/a-f; captured when go is accepted.
- ld_en  in  1  buffer write strobe; honoured only in IDLE/DONE.
- ld_addr  in  AW  buffer write address.
- ld_data  in  8  buffer write data.
- busy  out  1  high in SCAN/DWAIT/DSHOW.
- count  out  CW  number of conversions in the current/last run.
- done  out  1  high in DONE only.
- disp_valid  out  1  one-cycle pulse per displayed entry.
- disp_addr  out  AW  index of displayed entry.
- disp_data  out  8  buffer contents at disp_addr.

Behaviour:
- Reset (Rst=1 at an edge, from any state, including mid-scan or mid-display):
  - state=IDLE; busy=0, count=0, done=0, disp_valid=0, disp_addr=0, disp_data=0; internal idx=0, dwell counter=0.
  - Buffer contents are NOT cleared.
- IDLE:
  - ld_en writes ld_data to mem[ld_addr] at the edge; ld_addr ≥ DEPTH is ignored.
  - go=1 → SCAN next cycle. Same edge: idx=0, count=0, hex_mode latched.
  - If ld_en and go are high together, the write lands first; the scan sees the new data.
- SCAN, one entry per cycle:
  - Read mem[idx] combinationally.
  - Match when value is 48..57, or (latched hex_mode) 65..70 or 97..102.
  - On a match: mem[idx] ← value−48, value−55, or value−87 respectively (result 0..15, upper bits 0); count+1 at the same edge.
  - Non-matching entries are left unchanged.
  - Exit to DWAIT when idx==DEPTH−1 or count reaches MAX_HITS after this entry; otherwise idx+1.
  - On exit: idx=0, dwell=0.
  - Scan latency: at most DEPTH cycles.
- DWAIT: dwell increments each cycle; when dwell==WAIT_CYCLES−1 → DSHOW.
- DSHOW (1 cycle):
  - disp_valid=1, disp_addr=idx, disp_data=mem[idx] (registered outputs, valid in the DSHOW cycle).
  - If idx==DEPTH−1 → DONE; else idx+1, dwell=0 → DWAIT.
  - All DEPTH entries are displayed regardless of early scan stop. Interval between pulses = WAIT_CYCLES+1 cycles.
- DONE:
  - done=1; count holds its value.
  - ld_en is honoured; go=1 restarts exactly as from IDLE (done drops the next cycle). go held high continuously restarts immediately.
- ld_en and go are ignored while busy=1.
- disp_addr and disp_data hold their last values between pulses.
- Converted entries are not re-matched on a rerun: their values are 0..15, which never match.

Test Plan:
- Reset, load "a1B9" + 12×"Z", go=1, hex_mode=0 → mem = 'a',1,'B',9,'Z'...; count=2; done after 16 scan cycles + 16×(WAIT_CYCLES+1) cycles (WAIT_CYCLES=3 in bench).
- Same load, hex_mode=1 → mem = 10,1,11,9,...; count=4.
- Load 16×'5' → scan stops after 8 entries (idx 7); mem[0..7]=5, mem[8..15]='5'(53); count=8; still 16 disp_valid pulses, addresses 0..15 in order.
- Assert Rst during DWAIT after the 3rd pulse → next cycle busy=0, done=0, count=0, disp_valid=0; buffer still holds converted values; rerun with go → count=0 (nothing re-matches).
- ld_en with ld_addr=3, ld_data='7' during SCAN → mem[3] unchanged. In DONE, the same write followed by go → mem[3]=7, count=1.
- Boundary characters '/'(47), ':'(58), '@'(64), 'G'(71), '`'(96), 'g'(103) with hex_mode=1 → all unchanged, count=0.

Source files
------------

// File: rtl/ascii_digit_scan_conv.sv
// Character buffer that converts ASCII digits in place (decimal or hex), then
// replays every entry on a paced display port for a seven-segment/LED driver.
module ascii_digit_scan_conv #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int MAX_HITS    = 8,
  parameter int CW          = 5,
  parameter int WAIT_CYCLES = 10000
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          go,
  input  logic          hex_mode,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          disp_valid,
  output logic [AW-1:0] disp_addr,
  output logic [7:0]    disp_data
);

  localparam int DW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, DWAIT, DSHOW, DONE} state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [DW-1:0] dwell;
  logic          hex_l;
  logic [7:0]    mem [DEPTH];

  logic [7:0] cur;
  logic [7:0] conv;
  logic       match;
  logic       ld_ok;
  logic       scan_last;

  assign cur   = mem[idx];
  assign ld_ok = (state == IDLE || state == DONE) && ld_en && (32'(ld_addr) < 32'(DEPTH));

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    match = 1'b0;
    conv  = cur;
    if (cur >= 8'd48 && cur <= 8'd57) begin
      match = 1'b1;
      conv  = cur - 8'd48;
    end else if (hex_l && cur >= 8'd65 && cur <= 8'd70) begin
      match = 1'b1;
      conv  = cur - 8'd55;
    end else if (hex_l && cur >= 8'd97 && cur <= 8'd102) begin
      match = 1'b1;
      conv  = cur - 8'd87;
    end
  end

  // Early stop happens when this entry's hit brings the total to MAX_HITS.
  assign scan_last = (idx == AW'(DEPTH - 1)) || (match && (count == CW'(MAX_HITS - 1)));

  // NOTE: the buffer has no reset; it is a plain RAM whose contents must
  // survive Rst. Writes are only suppressed while Rst is asserted.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (ld_ok)
        mem[ld_addr] <= ld_data;
      else if (state == SCAN && match)
        mem[idx] <= conv;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      count      <= '0;
      done       <= 1'b0;
      disp_valid <= 1'b0;
      disp_addr  <= '0;
      disp_data  <= '0;
      idx        <= '0;
      dwell      <= '0;
      hex_l      <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (go) begin
            state <= SCAN;
            busy  <= 1'b1;
            done  <= 1'b0;
            idx   <= '0;
            count <= '0;
            hex_l <= hex_mode;
          end
        end
        SCAN: begin
          if (match)
            count <= count + 1'b1;
          if (scan_last) begin
            state <= DWAIT;
            idx   <= '0;
            dwell <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DWAIT: begin
          if (dwell == DW'(WAIT_CYCLES - 1)) begin
            // Load the display registers so they are valid during DSHOW.
            state      <= DSHOW;
            disp_valid <= 1'b1;
            disp_addr  <= idx;
            disp_data  <= mem[idx];
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        DSHOW: begin
          if (idx == AW'(DEPTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= DWAIT;
            idx   <= idx + 1'b1;
            dwell <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_digit_scan_conv.sv
// Self-checking bench for ascii_digit_scan_conv: a character-level model of the
// buffer predicts conversions, hit counts, display contents and pulse timing.
module tb_ascii_digit_scan_conv;

  localparam int DEPTH       = 16;
  localparam int AW          = 4;
  localparam int MAX_HITS    = 8;
  localparam int CW          = 5;
  localparam int WAIT_CYCLES = 3;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          go;
  logic          hex_mode;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic          busy;
  logic [CW-1:0] count;
  logic          done;
  logic          disp_valid;
  logic [AW-1:0] disp_addr;
  logic [7:0]    disp_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model_mem [DEPTH];

  ascii_digit_scan_conv #(
    .DEPTH(DEPTH), .AW(AW), .MAX_HITS(MAX_HITS), .CW(CW), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .Clk(Clk), .Rst(Rst), .go(go), .hex_mode(hex_mode),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .count(count), .done(done),
    .disp_valid(disp_valid), .disp_addr(disp_addr), .disp_data(disp_data)
  );

  always #5 Clk = ~Clk;

  task automatic load(input int a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    @(posedge Clk); #1;
    ld_en = 1'b0;
    if (a < DEPTH) model_mem[a] = d;
  endtask

  task automatic load_str(input string s, input logic [7:0] fill);
    for (int i = 0; i < DEPTH; i++)
      load(i, (i < s.len()) ? s[i] : fill);
  endtask

  // Character-level reference: convert digits in order until MAX_HITS.
  task automatic model_scan(input bit hex, output int hits, output int len);
    logic [7:0] c;
    hits = 0;
    len  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      c   = model_mem[i];
      len = i + 1;
      if (c inside {["0":"9"]}) begin
        model_mem[i] = c - "0"; hits++;
      end else if (hex && c inside {["A":"F"]}) begin
        model_mem[i] = c - "A" + 8'd10; hits++;
      end else if (hex && c inside {["a":"f"]}) begin
        model_mem[i] = c - "a" + 8'd10; hits++;
      end
      if (hits == MAX_HITS) break;
    end
  endtask

  // Start a run and monitor it until done (or until stop_after pulses).
  task automatic run(input bit hex, input bit hold, input int stop_after,
                     input bit scan_ld, output int got_count);
    int exp_hits, scan_len, pulses, cyc, exp_t;
    bit fin;
    model_scan(hex, exp_hits, scan_len);
    go = 1'b1;
    hex_mode = hex;
    @(posedge Clk); #1;
    ld_en = 1'b0;
    if (!hold) go = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL start: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    pulses = 0;
    cyc    = 0;
    fin    = 1'b0;
    while (!fin) begin
      @(posedge Clk); #1;
      cyc++;
      if (scan_ld) begin
        ld_en   = (cyc < 30);
        ld_addr = AW'(3);
        ld_data = "7";
      end
      if (disp_valid) begin
        exp_t = scan_len + WAIT_CYCLES + pulses * (WAIT_CYCLES + 1);
        n_cmp++;
        if (pulses >= DEPTH || cyc != exp_t || disp_addr !== AW'(pulses) ||
            disp_data !== model_mem[pulses % DEPTH]) begin
          n_err++;
          $display("FAIL pulse%0d: cyc=%0d addr=%0d data=%0d, required cyc=%0d addr=%0d data=%0d",
                   pulses, cyc, disp_addr, disp_data, exp_t, pulses, model_mem[pulses % DEPTH]);
        end
        pulses++;
        if (stop_after > 0 && pulses == stop_after) fin = 1'b1;
      end
      if (!fin && done) begin
        n_cmp++;
        if (cyc != scan_len + DEPTH * (WAIT_CYCLES + 1) || pulses != DEPTH ||
            count !== CW'(exp_hits) || busy !== 1'b0) begin
          n_err++;
          $display("FAIL done: cyc=%0d pulses=%0d count=%0d busy=%b, required cyc=%0d pulses=%0d count=%0d busy=0",
                   cyc, pulses, count, busy, scan_len + DEPTH * (WAIT_CYCLES + 1), DEPTH, exp_hits);
        end
        fin = 1'b1;
      end
      if (!fin && cyc >= 1000) begin
        n_err++;
        $display("FAIL timeout: no done after %0d cycles, pulses=%0d", cyc, pulses);
        fin = 1'b1;
      end
    end
    ld_en = 1'b0;
    got_count = int'(count);
  endtask

  task automatic expect_count(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: count=%0d, required %0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1; go = 1'b0; hex_mode = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== '0 || disp_valid !== 1'b0 ||
        disp_addr !== '0 || disp_data !== '0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b count=%0d dv=%b addr=%0d data=%0d, required all 0",
               busy, done, count, disp_valid, disp_addr, disp_data);
    end
  endtask

  task automatic test_decimal;
    int c;
    load_str("a1B9", "Z");
    run(1'b0, 1'b0, 0, 1'b0, c);
    expect_count("decimal", c, 2);
  endtask

  task automatic test_hex;
    int c;
    load_str("a1B9", "Z");
    run(1'b1, 1'b0, 0, 1'b0, c);
    expect_count("hex", c, 4);
  endtask

  task automatic test_early_stop;
    int c;
    load_str("", "5");
    run(1'b0, 1'b0, 0, 1'b0, c);
    expect_count("early_stop", c, MAX_HITS);
  endtask

  task automatic test_mid_reset;
    int c;
    load_str("a1B9", "Z");
    run(1'b1, 1'b0, 3, 1'b0, c);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== '0 || disp_valid !== 1'b0 ||
        disp_addr !== '0 || disp_data !== '0) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b done=%b count=%0d dv=%b addr=%0d data=%0d, required all 0",
               busy, done, count, disp_valid, disp_addr, disp_data);
    end
    run(1'b1, 1'b0, 0, 1'b0, c);
    expect_count("rerun", c, 0);
  endtask

  task automatic test_load_guard;
    int c;
    load_str("", "Z");
    run(1'b0, 1'b0, 0, 1'b1, c);
    expect_count("busy_load", c, 0);
    load(3, "7");
    run(1'b0, 1'b0, 0, 1'b0, c);
    expect_count("done_load", c, 1);
    // Write and go on the same edge: the scan must see the new character.
    ld_en = 1'b1; ld_addr = AW'(5); ld_data = "9";
    model_mem[5] = "9";
    run(1'b0, 1'b0, 0, 1'b0, c);
    expect_count("load_with_go", c, 1);
  endtask

  task automatic test_boundary;
    int c;
    load_str("/:@G`g", "Z");
    run(1'b1, 1'b0, 0, 1'b0, c);
    expect_count("boundary", c, 0);
  endtask

  task automatic test_random;
    int c;
    logic [7:0] ch;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom_range(0, 3))
          0:       ch = 8'("0" + $urandom_range(0, 9));
          1:       ch = 8'("A" + $urandom_range(0, 5));
          2:       ch = 8'("a" + $urandom_range(0, 5));
          default: ch = 8'($urandom_range(0, 255));
        endcase
        load(i, ch);
      end
      run(1'($urandom_range(0, 1)), 1'b0, 0, 1'b0, c);
    end
  endtask

  task automatic test_back_to_back;
    int c;
    load_str("", "3");
    run(1'b0, 1'b1, 0, 1'b0, c);
    expect_count("b2b_first", c, MAX_HITS);
    run(1'b0, 1'b0, 0, 1'b0, c);
    expect_count("b2b_second", c, DEPTH - MAX_HITS);
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_hex();
    test_early_stop();
    test_mid_reset();
    test_load_guard();
    test_boundary();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
